// File: rtl/vx_ifetch_stage.sv
// vx_ifetch_stage: instruction fetch between warp scheduler and decode.
// One fetch in flight per warp; per-warp metadata table; registered output FIFO.
// Ports: clk, reset (async active-low)
//   sched_*      : scheduled warp in (valid/ready, wid, tmask, pc, uuid)
//   icache_req_* : word-address request tagged by wid
//   icache_rsp_* : tagged instruction response
//   fetch_*      : instruction + metadata to decode (valid/ready)
//   pending_mask, rsp_err (sticky), busy (registered)
// Optional: define IFETCH_PERF_EN to add perf_icache_stalls, perf_fetch_latency.
module vx_ifetch_stage #(
  parameter  int NUM_WARPS   = 4,
  parameter  int NUM_THREADS = 4,
  parameter  int XLEN        = 32,
  parameter  int UUID_WIDTH  = 44,
  parameter  int OUT_DEPTH   = 2,
  localparam int NW_WIDTH    = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
`ifdef IFETCH_PERF_EN
  output logic [63:0]            perf_icache_stalls,
  output logic [63:0]            perf_fetch_latency,
`endif
  input  logic                   sched_valid,
  output logic                   sched_ready,
  input  logic [NW_WIDTH-1:0]    sched_wid,
  input  logic [NUM_THREADS-1:0] sched_tmask,
  input  logic [XLEN-1:0]        sched_pc,
  input  logic [UUID_WIDTH-1:0]  sched_uuid,
  output logic                   icache_req_valid,
  input  logic                   icache_req_ready,
  output logic [XLEN-3:0]        icache_req_addr,
  output logic [NW_WIDTH-1:0]    icache_req_tag,
  input  logic                   icache_rsp_valid,
  output logic                   icache_rsp_ready,
  input  logic [NW_WIDTH-1:0]    icache_rsp_tag,
  input  logic [31:0]            icache_rsp_data,
  output logic                   fetch_valid,
  input  logic                   fetch_ready,
  output logic [NW_WIDTH-1:0]    fetch_wid,
  output logic [NUM_THREADS-1:0] fetch_tmask,
  output logic [XLEN-1:0]        fetch_pc,
  output logic [UUID_WIDTH-1:0]  fetch_uuid,
  output logic [31:0]            fetch_instr,
  output logic [NUM_WARPS-1:0]   pending_mask,
  output logic                   rsp_err,
  output logic                   busy
);

  localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CW = $clog2(OUT_DEPTH + 1);

  typedef struct packed {
    logic [NW_WIDTH-1:0]    wid;
    logic [NUM_THREADS-1:0] tmask;
    logic [XLEN-1:0]        pc;
    logic [UUID_WIDTH-1:0]  uuid;
    logic [31:0]            instr;
  } ent_t;

  logic [NUM_WARPS-1:0]   pending_q;
  logic [NUM_WARPS-1:0]   pending_d;
  logic [XLEN-1:0]        tbl_pc    [NUM_WARPS];
  logic [NUM_THREADS-1:0] tbl_tmask [NUM_WARPS];
  logic [UUID_WIDTH-1:0]  tbl_uuid  [NUM_WARPS];
  ent_t                   fifo      [OUT_DEPTH];
  logic [PW-1:0]          rd_q;
  logic [PW-1:0]          wr_q;
  logic [CW-1:0]          cnt_q;
  logic                   rsp_err_q;
  logic                   busy_q;

  logic full;
  logic empty;
  logic credit;
  logic sched_blk;
  logic req_fire;
  logic rsp_fire;
  logic push;
  logic pop;
  ent_t push_ent;
  ent_t head;

  always_comb begin
    full   = (cnt_q == CW'(OUT_DEPTH));
    empty  = (cnt_q == '0);
    credit = ($countones(pending_q) + 32'(cnt_q))
             < 32'(OUT_DEPTH + NUM_WARPS);
    // a warp with a fetch in flight cannot be rescheduled
    sched_blk = pending_q[sched_wid] | ~credit;
  end

  assign icache_req_valid = sched_valid & ~sched_blk;
  assign sched_ready      = icache_req_ready & ~sched_blk;
  assign icache_req_addr  = sched_pc[XLEN-1:2];
  assign icache_req_tag   = sched_wid;
  assign req_fire         = sched_valid & sched_ready;

  assign icache_rsp_ready = ~full;
  assign rsp_fire         = icache_rsp_valid & icache_rsp_ready;
  assign push             = rsp_fire & pending_q[icache_rsp_tag];
  assign pop              = ~empty & fetch_ready;

  always_comb begin
    push_ent.wid   = icache_rsp_tag;
    push_ent.tmask = tbl_tmask[icache_rsp_tag];
    push_ent.pc    = tbl_pc[icache_rsp_tag];
    push_ent.uuid  = tbl_uuid[icache_rsp_tag];
    push_ent.instr = icache_rsp_data;
  end

  // request and response never touch the same warp in one cycle
  always_comb begin
    pending_d = pending_q;
    if (push)     pending_d[icache_rsp_tag] = 1'b0;
    if (req_fire) pending_d[sched_wid]      = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_q <= '0;
      rd_q      <= '0;
      wr_q      <= '0;
      cnt_q     <= '0;
      rsp_err_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      pending_q <= pending_d;
      if (push) wr_q <= wr_q + PW'(1);
      if (pop)  rd_q <= rd_q + PW'(1);
      cnt_q     <= cnt_q + CW'(push) - CW'(pop);
      if (rsp_fire & ~pending_q[icache_rsp_tag])
        rsp_err_q <= 1'b1;
      busy_q    <= (|pending_q) | ~empty;
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) begin
      tbl_pc[sched_wid]    <= sched_pc;
      tbl_tmask[sched_wid] <= sched_tmask;
      tbl_uuid[sched_wid]  <= sched_uuid;
    end
    if (push) fifo[wr_q] <= push_ent;
  end

  assign head         = fifo[rd_q];
  assign fetch_valid  = ~empty;
  assign fetch_wid    = head.wid;
  assign fetch_tmask  = head.tmask;
  assign fetch_pc     = head.pc;
  assign fetch_uuid   = head.uuid;
  assign fetch_instr  = head.instr;
  assign pending_mask = pending_q;
  assign rsp_err      = rsp_err_q;
  assign busy         = busy_q;

`ifdef IFETCH_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_icache_stalls <= '0;
      perf_fetch_latency <= '0;
    end else begin
      if (icache_req_valid & ~icache_req_ready)
        perf_icache_stalls <= perf_icache_stalls + 64'd1;
      perf_fetch_latency <= perf_fetch_latency
                            + 64'($countones(pending_q));
    end
  end
`endif

endmodule

// File: doc/vx_ifetch_stage.md
Name: vx_ifetch_stage

Overview:
- Instruction-fetch stage directly downstream of the warp scheduler.
- Accepts one scheduled warp per cycle (wid, tmask, PC, uuid) and issues a word-aligned I-cache request tagged by wid.
- Holds per-warp metadata until the response returns, then emits the instruction with its metadata to decode through a small output buffer.
- At most one fetch in flight per warp.

Parameters:
- NUM_WARPS, 4, warps per core.
- NUM_THREADS, 4, threads per warp.
- XLEN, 32, PC width.
- UUID_WIDTH, 44, instruction uuid width.
- OUT_DEPTH, 2, output buffer entries (power of two, ≥2).
- NW_WIDTH, derived as max(1, clog2(NUM_WARPS)), wid width; not user-set.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- sched_valid  in  1  scheduled warp valid
- sched_ready  out  1  stage accepts scheduled warp
- sched_wid  in  NW_WIDTH  warp id
- sched_tmask  in  NUM_THREADS  thread mask
- sched_pc  in  XLEN  fetch PC
- sched_uuid  in  UUID_WIDTH  instruction uuid
- icache_req_valid  out  1  request valid
- icache_req_ready  in  1  I-cache accepts request
- icache_req_addr  out  XLEN-2  word address, equal to sched_pc[XLEN-1:2]
- icache_req_tag  out  NW_WIDTH  equal to sched_wid
- icache_rsp_valid  in  1  response valid
- icache_rsp_ready  out  1  stage accepts response
- icache_rsp_tag  in  NW_WIDTH  response wid
- icache_rsp_data  in  32  instruction word
- fetch_valid  out  1  decoded-side valid
- fetch_ready  in  1  decode accepts
- fetch_wid / fetch_tmask / fetch_pc / fetch_uuid  out  NW_WIDTH / NUM_THREADS / XLEN / UUID_WIDTH  metadata
- fetch_instr  out  32  instruction
- pending_mask  out  NUM_WARPS  warps with a fetch in flight
- rsp_err  out  1  sticky: response arrived for a non-pending tag
- busy  out  1  any pending fetch or non-empty output buffer

Behaviour:
- Reset (reset=0, asynchronous): pending_mask=0, output buffer empty, fetch_valid=0, icache_req_valid=0, rsp_err=0, busy=0. Metadata table is not reset.
- Request path is combinational with zero added latency.
  - Let credit = (popcount(pending_mask) + buffer occupancy) < OUT_DEPTH + NUM_WARPS.
  - icache_req_valid = sched_valid & ~pending_mask[sched_wid] & credit. It must not depend on icache_req_ready.
  - sched_ready = icache_req_ready & ~pending_mask[sched_wid] & credit.
- Request fire (sched_valid & sched_ready):
  - table[sched_wid] <= {pc, tmask, uuid}.
  - pending_mask[sched_wid] <= 1.
- Response path:
  - icache_rsp_ready = ~buffer_full.
  - On fire with pending_mask[tag]=1: push {tag, table[tag], data} into the output FIFO and clear pending_mask[tag] next cycle.
  - On fire with pending_mask[tag]=0: drop the beat, set rsp_err=1 (sticky until reset), FIFO unchanged.
- Output: FIFO head drives fetch_*. fetch_valid = ~empty. Pop on fetch_valid & fetch_ready.
  - Latency: response fire to fetch_valid is 1 cycle (registered FIFO).
  - Full FIFO: icache_rsp_ready=0; the response must be held by the I-cache.
  - Simultaneous push and pop when full is not allowed, because ready is derived from full. When neither empty nor full, occupancy is unchanged.
- Same-cycle events:
  - Response for warp W and a new schedule for W: the schedule is blocked that cycle (pending still set) and can fire the next cycle.
  - Request for W1 and response for W2 in the same cycle: both proceed. Table write and read use distinct entries.
- Ordering: responses may return out of order across warps. Output order equals response acceptance order.
- busy = (pending_mask != 0) | ~empty, registered, so it is 1 cycle delayed.
- Fetch_instr is passed through unmodified. PC bits [1:0] are ignored for addressing but kept in fetch_pc.

Optional Feature:
- Macro: IFETCH_PERF_EN.
- When defined, adds outputs perf_icache_stalls (64) and perf_fetch_latency (64).
  - perf_icache_stalls increments each cycle icache_req_valid & ~icache_req_ready.
  - perf_fetch_latency adds popcount(pending_mask) each cycle.
  - Both reset to 0 and wrap on overflow.
- When undefined, these ports and counters do not exist, and all other behaviour is identical.

Test Plan:
- Single fetch: sched wid=1, pc=0x80000004, tmask=4'b0011, uuid=5, with I-cache responding data=0x00000013 two cycles later.
  - Expect req addr=0x20000001, tag=1.
  - Expect fetch_valid 1 cycle after the response, carrying wid=1, pc=0x80000004, tmask=0011, instr=0x13, uuid=5.
  - pending_mask returns to 0.
- Duplicate warp block: schedule wid=2 twice back-to-back with no response.
  - Expect the second sched_ready=0 until the cycle after the rsp fire for tag 2.
- Out-of-order: issue wid0 then wid3, respond tag3 then tag0.
  - Expect fetch order wid3, wid0, each with correct pc/uuid.
- Backpressure: fetch_ready=0, three responses from wids 0,1,2 with OUT_DEPTH=2.
  - Expect the third icache_rsp_ready=0 until one pop.
  - Expect no data loss.
- Spurious response: rsp tag=3 with pending_mask=0.
  - Expect rsp_err=1, no fetch_valid, and rsp_err still 1 after 100 cycles.
- Async reset mid-flight: assert reset=0 between clock edges while 2 fetches are pending and the FIFO holds 1 entry.
  - Expect pending_mask=0, fetch_valid=0, busy=0 immediately, without waiting for a clock edge.
